// File: rtl/rst_seq_gen_pkg.sv
// Shared types and timing helpers for the multi-channel reset sequencer.
package rst_seq_pkg;

   typedef enum logic {
      SEQ  = 1'b0,
      IDLE = 1'b1
   } state_e;

   // Counter value (edges after the trigger) on which channel k is released.
   function automatic int rel_cycle(int k, int rst_clk_cycles, int stagger_cycles);
      return rst_clk_cycles + k * stagger_cycles;
   endfunction

endpackage

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: holds selected reset outputs low, then
// releases them one by one with a fixed stagger. Supports a soft re-reset
// of a channel subset through a ready/valid request.
//
// state | meaning
// ------+---------------------------------------------------------------
// SEQ   | sequence running; counter advances, masked channels release
// IDLE  | all releases done; a request may be accepted
module rst_seq_gen
   import rst_seq_pkg::*;
#(
   parameter int NumRst        = 4,
   parameter int RstClkCycles  = 7,
   parameter int StaggerCycles = 2,
   parameter int CntWidth      = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   input  logic [NumRst-1:0] req_mask_i,
   output logic              req_ready_o,
   output logic [NumRst-1:0] rst_no,
   output logic              busy_o,
   output logic              done_o
);

   // The sequence always runs to the highest channel's release, whatever the mask.
   localparam int LastInt = rel_cycle(NumRst - 1, RstClkCycles, StaggerCycles);
   localparam logic [CntWidth-1:0] LastCnt = LastInt[CntWidth-1:0];

   if (NumRst < 1 || RstClkCycles < 1) begin : g_bad_cfg
      $fatal(1, "rst_seq_gen: NumRst and RstClkCycles must both be at least 1");
   end

   if (LastInt >= (1 << CntWidth)) begin : g_bad_width
      $fatal(1, "rst_seq_gen: CntWidth too small for the full sequence length");
   end

   state_e              state_q, state_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [CntWidth-1:0] cnt_inc;
   logic [NumRst-1:0]   mask_q, mask_d;
   logic [NumRst-1:0]   rst_q, rst_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [NumRst-1:0]   rel_hit;

   // Saturating count; the value it takes on this edge is what gets compared.
   assign cnt_inc = (cnt_q == LastCnt) ? cnt_q : cnt_q + CntWidth'(1);

   // One terminal-count compare per channel against its fixed release point.
   for (genvar k = 0; k < NumRst; k++) begin : g_rel
      localparam int RelInt = rel_cycle(k, RstClkCycles, StaggerCycles);
      localparam logic [CntWidth-1:0] RelCnt = RelInt[CntWidth-1:0];
      assign rel_hit[k] = (cnt_inc == RelCnt);
   end

   // Next-state logic: count and release in SEQ, accept soft requests in IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      rst_d   = rst_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         SEQ: begin
            cnt_d = cnt_inc;
            rst_d = rst_q | (rel_hit & mask_q);
            if (cnt_inc == LastCnt) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         IDLE: begin
            if (req_valid_i) begin
               state_d = SEQ;
               cnt_d   = '0;
               mask_d  = req_mask_i;
               rst_d   = rst_q & ~req_mask_i;
               busy_d  = 1'b1;
            end
         end
         default: state_d = SEQ;
      endcase
   end

   // State and output registers; synchronous reset restarts the full sequence.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= SEQ;
         cnt_q   <= '0;
         mask_q  <= '1;
         rst_q   <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         rst_q   <= rst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign rst_no      = rst_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default configuration plus two parameter
// sweep instances. Expected values are pushed to a scoreboard before each
// edge and popped/compared just after it.
module tb_rst_seq_gen;
   import rst_seq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut0: defaults (4 channels, 7 hold, 2 stagger)
   logic       rst_n0 = 1'b0, vld0 = 1'b0;
   logic [3:0] mask0 = '0;
   logic [3:0] rst_no0;
   logic       busy0, done0, rdy0;
   // dut1: 1 channel, 1 hold, 0 stagger
   logic       rst_n1 = 1'b0, vld1 = 1'b0;
   logic [0:0] mask1 = '0;
   logic [0:0] rst_no1;
   logic       busy1, done1, rdy1;
   // dut2: 8 channels, 7 hold, 3 stagger
   logic       rst_n2 = 1'b0, vld2 = 1'b0;
   logic [7:0] mask2 = '0;
   logic [7:0] rst_no2;
   logic       busy2, done2, rdy2;

   rst_seq_gen u_dut0 (
      .clk_i(clk), .rst_ni(rst_n0), .req_valid_i(vld0), .req_mask_i(mask0),
      .req_ready_o(rdy0), .rst_no(rst_no0), .busy_o(busy0), .done_o(done0));

   rst_seq_gen #(.NumRst(1), .RstClkCycles(1), .StaggerCycles(0), .CntWidth(4)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n1), .req_valid_i(vld1), .req_mask_i(mask1),
      .req_ready_o(rdy1), .rst_no(rst_no1), .busy_o(busy1), .done_o(done1));

   rst_seq_gen #(.NumRst(8), .RstClkCycles(7), .StaggerCycles(3), .CntWidth(8)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n2), .req_valid_i(vld2), .req_mask_i(mask2),
      .req_ready_o(rdy2), .rst_no(rst_no2), .busy_o(busy2), .done_o(done2));

   typedef struct {
      int         dut;
      string      tag;
      logic [7:0] rst;
      logic       busy;
      logic       done;
      logic       rdy;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Expected outputs n edges after trigger T, given the sequence mask and
   // the output value held just before T.
   function automatic exp_t model(int dut, string tag, int n, logic [7:0] mask, logic [7:0] prev);
      int   nr, rc, st, last;
      exp_t e;
      case (dut)
         0:       begin nr = 4; rc = 7; st = 2; end
         1:       begin nr = 1; rc = 1; st = 0; end
         default: begin nr = 8; rc = 7; st = 3; end
      endcase
      last  = rel_cycle(nr - 1, rc, st);
      e.dut = dut;
      e.tag = tag;
      e.rst = '0;
      for (int k = 0; k < nr; k++)
         e.rst[k] = !mask[k] ? prev[k] : (n >= rel_cycle(k, rc, st));
      e.busy = (n < last);
      e.done = (n == last);
      e.rdy  = (n >= last);
      return e;
   endfunction

   task automatic check(exp_t e);
      logic [7:0] o_rst;
      logic       o_busy, o_done, o_rdy;
      case (e.dut)
         0:       begin o_rst = {4'b0, rst_no0}; o_busy = busy0; o_done = done0; o_rdy = rdy0; end
         1:       begin o_rst = {7'b0, rst_no1}; o_busy = busy1; o_done = done1; o_rdy = rdy1; end
         default: begin o_rst = rst_no2;         o_busy = busy2; o_done = done2; o_rdy = rdy2; end
      endcase
      checks++;
      assert (o_rst === e.rst) else begin
         errors++;
         $error("FAIL dut%0d %s rst_no: got %h expected %h", e.dut, e.tag, o_rst, e.rst);
      end
      checks++;
      assert (o_busy === e.busy) else begin
         errors++;
         $error("FAIL dut%0d %s busy_o: got %b expected %b", e.dut, e.tag, o_busy, e.busy);
      end
      checks++;
      assert (o_done === e.done) else begin
         errors++;
         $error("FAIL dut%0d %s done_o: got %b expected %b", e.dut, e.tag, o_done, e.done);
      end
      checks++;
      assert (o_rdy === e.rdy) else begin
         errors++;
         $error("FAIL dut%0d %s req_ready_o: got %b expected %b", e.dut, e.tag, o_rdy, e.rdy);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      while (sb.size() != 0) check(sb.pop_front());
   endtask

   initial begin
      // power-on: three low edges (reset values), then release
      for (int i = 0; i < 3; i++) begin
         sb.push_back(model(0, "por_hold", 0, 8'hff, 8'h00));
         step();
      end
      rst_n0 = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         sb.push_back(model(0, "por", n, 8'hff, 8'h00));
         step();
      end

      // soft reset of channels 0 and 2; 1 and 3 must stay high
      vld0 = 1'b1; mask0 = 4'b0101;
      sb.push_back(model(0, "soft_acc", 0, 8'h05, 8'h0f));
      step();
      vld0 = 1'b0; mask0 = '0;
      for (int n = 1; n <= 15; n++) begin
         sb.push_back(model(0, "soft", n, 8'h05, 8'h0f));
         step();
      end

      // request held during a power-on sequence: ignored until ready
      rst_n0 = 1'b0;
      sb.push_back(model(0, "busy_rst", 0, 8'hff, 8'h0f));
      step();
      rst_n0 = 1'b1; vld0 = 1'b1; mask0 = 4'b0011;
      for (int n = 1; n <= 13; n++) begin
         sb.push_back(model(0, "busy_req", n, 8'hff, 8'h00));
         step();
      end
      sb.push_back(model(0, "busy_acc", 0, 8'h03, 8'h0f));
      step();
      vld0 = 1'b0; mask0 = '0;
      for (int n = 1; n <= 14; n++) begin
         sb.push_back(model(0, "post_busy", n, 8'h03, 8'h0f));
         step();
      end

      // abort a soft sequence at edge 10; soft mask must be discarded
      vld0 = 1'b1; mask0 = 4'b0110;
      sb.push_back(model(0, "abort_acc", 0, 8'h06, 8'h0f));
      step();
      vld0 = 1'b0; mask0 = '0;
      for (int n = 1; n <= 9; n++) begin
         sb.push_back(model(0, "abort_pre", n, 8'h06, 8'h0f));
         step();
      end
      rst_n0 = 1'b0;
      sb.push_back(model(0, "abort", 0, 8'hff, 8'h0f));
      step();
      rst_n0 = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         sb.push_back(model(0, "abort_re", n, 8'hff, 8'h00));
         step();
      end

      // zero mask: outputs untouched, full-length busy and one done pulse
      vld0 = 1'b1; mask0 = 4'b0000;
      sb.push_back(model(0, "zero_acc", 0, 8'h00, 8'h0f));
      step();
      vld0 = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         sb.push_back(model(0, "zero", n, 8'h00, 8'h0f));
         step();
      end

      // parameter sweep instances: power-on sequences run side by side
      for (int i = 0; i < 2; i++) begin
         sb.push_back(model(1, "sw1_hold", 0, 8'hff, 8'h00));
         sb.push_back(model(2, "sw2_hold", 0, 8'hff, 8'h00));
         step();
      end
      rst_n1 = 1'b1; rst_n2 = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         sb.push_back(model(1, "sw1", n, 8'hff, 8'h00));
         sb.push_back(model(2, "sw2", n, 8'hff, 8'h00));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
